// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// fixed 34-cycle start-to-done latency for every operation.
module mul_div_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned ITER = 32
) (
  input  logic            CLOCK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  output logic [XLEN-1:0] RESULT,
  output logic            BUSY,
  output logic            DONE
);

  localparam int unsigned CntW = $clog2(ITER);
  localparam logic [CntW-1:0] CntLast = CntW'(ITER - 1);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                sgn1_q, sgn1_d;
  logic                div0_q, div0_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     a_q, a_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quo_q, quo_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]     data1_q, data1_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                in_signed1, in_signed2, in_sgn1, in_sgn2;
  logic [XLEN-1:0]     mag1, mag2;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_part;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix, rem_fix, fin_res;

  // Operand signedness decoded from the incoming funct3.
  assign in_signed1 = !(FUNCT3 == 3'b011 || FUNCT3 == 3'b101 || FUNCT3 == 3'b111);
  assign in_signed2 = (FUNCT3 == 3'b000 || FUNCT3 == 3'b001 ||
                       FUNCT3 == 3'b100 || FUNCT3 == 3'b110);
  assign in_sgn1    = in_signed1 & DATA1[XLEN-1];
  assign in_sgn2    = in_signed2 & DATA2[XLEN-1];
  assign mag1       = in_sgn1 ? -DATA1 : DATA1;
  assign mag2       = in_sgn2 ? -DATA2 : DATA2;

  // Multiplier bits live in the low half of prod_q and shift out LSB first.
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : '0)};

  // When the trial subtraction succeeds the true difference is below the divisor,
  // so the modulo-2^XLEN difference is exact.
  assign div_part = {rem_q, quo_q[XLEN-1]};
  assign div_ge   = div_part >= {1'b0, b_q};
  assign div_diff = div_part[XLEN-1:0] - b_q;

  always_comb begin
    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = sgn1_q ? -rem_q : rem_q;
    fin_res  = '0;
    case (op_q)
      3'b000:                 fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_fix[2*XLEN-1:XLEN];
      3'b100:                 fin_res = div0_q ? '1 : (ovf_q ? MinNeg : quo_fix);
      3'b101:                 fin_res = div0_q ? '1 : quo_fix;
      3'b110:                 fin_res = div0_q ? data1_q : (ovf_q ? '0 : rem_fix);
      default:                fin_res = div0_q ? data1_q : rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    sgn1_d   = sgn1_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    data1_d  = data1_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) begin
          op_d    = FUNCT3;
          sgn1_d  = in_sgn1;
          neg_d   = in_sgn1 ^ in_sgn2;
          a_d     = mag1;
          b_d     = mag2;
          prod_d  = {{XLEN{1'b0}}, mag2};
          rem_d   = '0;
          quo_d   = mag1;
          cnt_d   = '0;
          data1_d = DATA1;
          div0_d  = (DATA2 == '0);
          ovf_d   = (FUNCT3 == 3'b100 || FUNCT3 == 3'b110) &&
                    (DATA1 == MinNeg) && (DATA2 == '1);
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (op_q[2]) begin
          rem_d = div_ge ? div_diff : div_part[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], div_ge};
        end else begin
          prod_d = {mul_sum, prod_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFin;
        end
      end
      StFin: begin
        result_d = fin_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= StIdle;
      op_q     <= '0;
      neg_q    <= 1'b0;
      sgn1_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      data1_q  <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      sgn1_q   <= sgn1_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      b_q      <= b_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      data1_q  <= data1_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign RESULT = result_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed and random RV32M operations checked against an
// arithmetic reference model, plus latency, handshake and reset behaviour.
module tb_mul_div_unit;

  logic        CLOCK;
  logic        RESET;
  logic        START;
  logic [2:0]  FUNCT3;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic [31:0] RESULT;
  logic        BUSY;
  logic        DONE;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  logic [31:0] last_res = '0;

  mul_div_unit #(.XLEN(32), .ITER(32)) dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .START  (START),
    .FUNCT3 (FUNCT3),
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .RESULT (RESULT),
    .BUSY   (BUSY),
    .DONE   (DONE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'b0, b});
    ua64 = {32'b0, a};
    ub64 = {32'b0, b};
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation at exact latency: accept at E0, still busy at E32, done at E33.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [31:0] exp;
    exp = ref_op(f3, a, b);
    @(negedge CLOCK);
    START = 1'b1; FUNCT3 = f3; DATA1 = a; DATA2 = b;
    @(posedge CLOCK); #1;
    check($sformatf("%s.busy_e0", tag), {31'b0, BUSY}, 32'd1);
    START = 1'b0; DATA1 = $urandom; DATA2 = $urandom; FUNCT3 = 3'($urandom);
    repeat (32) @(posedge CLOCK);
    #1;
    check($sformatf("%s.busy_done_e32", tag), {30'b0, BUSY, DONE}, 32'd2);
    check($sformatf("%s.result_hold", tag), RESULT, last_res);
    @(posedge CLOCK); #1;
    check($sformatf("%s.busy_done_e33", tag), {30'b0, BUSY, DONE}, 32'd1);
    check($sformatf("%s.result", tag), RESULT, exp);
    last_res = exp;
  endtask

  initial begin
    logic [31:0] exp_a, exp_b, exp_c, ra, rb;
    logic [2:0]  rf;
    int          done_seen;

    RESET = 1'b1; START = 1'b0; FUNCT3 = '0; DATA1 = '0; DATA2 = '0;
    repeat (3) @(posedge CLOCK);
    #1;
    check("reset.busy_done", {30'b0, BUSY, DONE}, 32'd0);
    check("reset.result", RESULT, 32'd0);
    @(negedge CLOCK); RESET = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFFFFFD, "mul_7_m3");
    run_op(3'd1, 32'h80000000, 32'h80000000, "mulh_min");
    run_op(3'd3, 32'h80000000, 32'h80000000, "mulhu_min");
    run_op(3'd2, 32'h80000000, 32'h80000000, "mulhsu_min");
    run_op(3'd0, 32'h80000000, 32'h80000000, "mul_min");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, "div_m7_2");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2, "rem_m7_2");
    run_op(3'd5, 32'hFFFFFFF9, 32'd2, "divu_m7_2");
    run_op(3'd7, 32'hFFFFFFF9, 32'd2, "remu_m7_2");
    run_op(3'd4, 32'd5, 32'd0, "div_by0");
    run_op(3'd7, 32'd5, 32'd0, "remu_by0");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, "rem_ovf");

    // START held high: first operands only, second op accepted at the DONE-cycle edge.
    exp_a = ref_op(3'd0, 32'd5, 32'd6);
    exp_b = ref_op(3'd4, 32'hFFFFFF9C, 32'd7);
    @(negedge CLOCK);
    START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd5; DATA2 = 32'd6;
    @(posedge CLOCK); #1;
    check("hold.busy_e0", {31'b0, BUSY}, 32'd1);
    repeat (32) begin
      @(negedge CLOCK);
      DATA1 = $urandom; DATA2 = $urandom; FUNCT3 = 3'($urandom);
      @(posedge CLOCK);
    end
    #1;
    check("hold.busy_e32", {31'b0, BUSY}, 32'd1);
    @(negedge CLOCK);
    FUNCT3 = 3'd4; DATA1 = 32'hFFFFFF9C; DATA2 = 32'd7;
    @(posedge CLOCK); #1;
    check("hold.done_a", {30'b0, BUSY, DONE}, 32'd1);
    check("hold.result_a", RESULT, exp_a);
    @(posedge CLOCK); #1;
    check("hold.accept_b", {30'b0, BUSY, DONE}, 32'd2);
    START = 1'b0;
    repeat (32) @(posedge CLOCK);
    check("hold.result_a_stable", RESULT, exp_a);
    @(posedge CLOCK); #1;
    check("hold.done_b", {30'b0, BUSY, DONE}, 32'd1);
    check("hold.result_b", RESULT, exp_b);
    last_res = exp_b;

    // START pulses while busy are dropped, not queued.
    ra = $urandom; rb = $urandom;
    exp_c = ref_op(3'd2, ra, rb);
    @(negedge CLOCK);
    START = 1'b1; FUNCT3 = 3'd2; DATA1 = ra; DATA2 = rb;
    @(posedge CLOCK); #1;
    START = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLOCK);
      START = (i % 3 == 0); DATA1 = $urandom; DATA2 = $urandom; FUNCT3 = 3'($urandom);
    end
    START = 1'b0;
    @(posedge CLOCK);
    @(posedge CLOCK); #1;
    check("ignore.done", {30'b0, BUSY, DONE}, 32'd1);
    check("ignore.result", RESULT, exp_c);
    last_res = exp_c;
    @(posedge CLOCK); #1;
    check("ignore.no_queue", {30'b0, BUSY, DONE}, 32'd0);

    // Reset at E10 of a DIVU aborts it with no later DONE.
    @(negedge CLOCK);
    START = 1'b1; FUNCT3 = 3'd5; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLOCK); #1;
    START = 1'b0;
    repeat (9) @(posedge CLOCK);
    @(negedge CLOCK); RESET = 1'b1;
    @(posedge CLOCK); #1;
    check("midrst.busy_done", {30'b0, BUSY, DONE}, 32'd0);
    check("midrst.result", RESULT, 32'd0);
    last_res = '0;
    RESET = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge CLOCK); #1;
      if (DONE || BUSY) done_seen++;
    end
    check("midrst.quiet", done_seen, 32'd0);
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_after_rst");

    // Reset and START on the same edge: reset wins.
    @(negedge CLOCK);
    RESET = 1'b1; START = 1'b1; FUNCT3 = 3'd0; DATA1 = 32'd3; DATA2 = 32'd4;
    @(posedge CLOCK); #1;
    check("rst_start.busy", {30'b0, BUSY, DONE}, 32'd0);
    check("rst_start.result", RESULT, 32'd0);
    last_res = '0;
    RESET = 1'b0; START = 1'b0;
    @(posedge CLOCK); #1;
    check("rst_start.idle", {31'b0, BUSY}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, $sformatf("rand%0d_f%0d", i, rf));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
